// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier.
// Each clock in RUN adds one partial product, so a product takes WIDTH clocks.
// The start/busy/done handshake allows back-to-back operations.
// Optional feature macro: SHIFT_ADD_MUL_SIGNED_EN selects two's complement
// operands. The top partial product is then subtracted instead of added.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;

  logic            last_iter;
  logic [PW-1:0]   acc_sum;

  // Widen an operand to the product width at capture time.
  function automatic logic [PW-1:0] extend_operand(input logic [WIDTH-1:0] v);
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    return {{WIDTH{v[WIDTH-1]}}, v};
`else
    return {{WIDTH{1'b0}}, v};
`endif
  endfunction

  // Partial-product accumulation for the current iteration.
  always_comb begin
    last_iter = (cnt_q == CW'(WIDTH - 1));
    acc_sum   = acc_q;
    if (mplier_q[0]) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
      // The multiplier MSB carries negative weight in two's complement.
      if (last_iter) acc_sum = acc_q + ~mcand_q + PW'(1);
      else           acc_sum = acc_q + mcand_q;
`else
      acc_sum = acc_q + mcand_q;
`endif
    end
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = extend_operand(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          product_d = acc_sum;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier (WIDTH=8). The reference product comes from
// plain integer multiplication. SHIFT_ADD_MUL_SIGNED_EN selects signed mode.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint r;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = sx * sy;
`else
    longint ux, uy;
    ux = longint'(x);
    uy = longint'(y);
    r  = ux * uy;
`endif
    return r[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full multiply with cycle-accurate busy/done checks; ends one cycle
  // after the done cycle with start low, so the result must be held.
  task automatic mul_check(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2*W-1:0] exp, input string tag);
    start = 1'b1; a = x; b = y;
    tick;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " done_early"}, 64'(done), 64'd0);
      tick;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_off"}, 64'(busy), 64'd0);
    check({tag, " product"}, 64'(product), 64'(exp));
    tick;
    check({tag, " done_single"}, 64'(done), 64'd0);
    check({tag, " product_hold"}, 64'(product), 64'(exp));
  endtask

  initial begin
    int ndone;
    int seen;
    int t1;
    int t2;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    // Reset state
    tick; tick;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst product", 64'(product), 64'd0);
    rst_n = 1'b1;

    // Start coincident with reset release, basic products
    mul_check(8'd13, 8'd11, 16'h008F, "13x11");
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    mul_check(8'd255, 8'd255, 16'h0001, "m1xm1");
`else
    mul_check(8'd255, 8'd255, 16'hFE01, "255x255");
`endif
    mul_check(8'd0, 8'd200, 16'h0000, "0x200");

    // start pulses during RUN are ignored
    start = 1'b1; a = 8'd3; b = 8'd4;
    tick;
    ndone = 0;
    for (int j = 1; j <= W + 3; j++) begin
      if (j == 2 || j == 5) begin
        start = 1'b1; a = 8'd9; b = 8'd9;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      tick;
      if (done) begin
        ndone++;
        check("ignore product", 64'(product), 64'(ref_mul(8'd3, 8'd4)));
      end
    end
    start = 1'b0;
    check("ignore done_count", 64'(ndone), 64'd1);

    // Back-to-back with start held high
    start = 1'b1; a = 8'd2; b = 8'd3;
    tick;
    a = W'($urandom); b = W'($urandom);
    seen = 0; t1 = 0; t2 = 0;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (done) begin
        if (seen == 0) begin
          check("b2b product1", 64'(product), 64'(ref_mul(8'd2, 8'd3)));
          a = 8'd5; b = 8'd7; t1 = c;
        end else begin
          check("b2b product2", 64'(product), 64'(ref_mul(8'd5, 8'd7)));
          start = 1'b0; t2 = c;
        end
        seen++;
      end else begin
        a = W'($urandom); b = W'($urandom);
      end
      if (seen == 2) break;
    end
    start = 1'b0;
    check("b2b done_count", 64'(seen), 64'd2);
    check("b2b spacing", 64'(t2 - t1), 64'd9);
    tick;

    // Reset mid-RUN
    start = 1'b1; a = 8'd3; b = 8'd5;
    tick;
    start = 1'b0;
    tick; tick; tick;
    check("mid busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst done", 64'(done), 64'd0);
    check("mid rst product", 64'(product), 64'd0);
    tick; tick;
    rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 2 * W; j++) begin
      tick;
      if (done) ndone++;
    end
    check("mid no_done", 64'(ndone), 64'd0);
    mul_check(8'd6, 8'd7, 16'd42, "6x7");

`ifdef SHIFT_ADD_MUL_SIGNED_EN
    mul_check(8'hFD, 8'd5, 16'hFFF1, "s m3x5");
    mul_check(8'h80, 8'h80, 16'h4000, "s m128xm128");
    mul_check(8'd127, 8'hFF, 16'hFF81, "s 127xm1");
`endif

    // Randomized operands against the reference model
    for (int k = 0; k < 8; k++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      mul_check(rx, ry, ref_mul(rx, ry), $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
